// File: rtl/sigma_delta_decimator.sv
// Third-order CIC (sinc3) decimator: turns a 1-bit sigma-delta stream into
// signed 16-bit PCM, one sample per DECIM accepted bits, with output saturation.
module sigma_delta_decimator #(
    parameter int DECIM = 64
) (
    input  logic               i_clk,
    input  logic               i_res,
    input  logic               i_bit,
    input  logic               i_bit_valid,
    output logic signed [15:0] o_sample,
    output logic               o_valid,
    output logic               o_clip
);

    localparam int L     = $clog2(DECIM);
    localparam int W     = 3 * L + 2;
    localparam int SHIFT = 3 * L - 15;

    localparam logic signed [W-1:0] SAT_MAX = W'(32767);
    localparam logic signed [W-1:0] SAT_MIN = -W'(32768);

    logic signed [W-1:0] integ1_q, integ2_q, integ3_q;
    logic signed [W-1:0] integ1_d, integ2_d, integ3_d;
    logic signed [W-1:0] dly1_q, dly2_q, dly3_q;
    logic        [L-1:0] cnt_q;
    logic signed [15:0]  sample_q, sample_d;
    logic                clip_q, clip_d;
    logic                valid_q;

    logic signed [W-1:0] inVal;
    logic signed [W-1:0] comb1, comb2, combOut, scaled;
    logic                lastBit;

    // Direct cascade: each integrator sees the freshly updated value of the one before it.
    always_comb begin
        inVal    = i_bit ? W'(1) : {W{1'b1}};
        integ1_d = integ1_q + inVal;
        integ2_d = integ2_q + integ1_d;
        integ3_d = integ3_q + integ2_d;
        lastBit  = (cnt_q == L'(DECIM - 1));

        comb1    = integ3_d - dly1_q;
        comb2    = comb1 - dly2_q;
        combOut  = comb2 - dly3_q;
        scaled   = combOut >>> SHIFT;

        sample_d = scaled[15:0];
        clip_d   = 1'b0;
        if (scaled > SAT_MAX) begin
            sample_d = 16'sh7FFF;
            clip_d   = 1'b1;
        end else if (scaled < SAT_MIN) begin
            sample_d = -16'sh8000;
            clip_d   = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_res) begin
            integ1_q <= '0;
            integ2_q <= '0;
            integ3_q <= '0;
            dly1_q   <= '0;
            dly2_q   <= '0;
            dly3_q   <= '0;
            cnt_q    <= '0;
            sample_q <= '0;
            clip_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= i_bit_valid && lastBit;
            if (i_bit_valid) begin
                integ1_q <= integ1_d;
                integ2_q <= integ2_d;
                integ3_q <= integ3_d;
                cnt_q    <= cnt_q + L'(1);
                // Comb delays only advance at the decimated rate.
                if (lastBit) begin
                    dly1_q   <= integ3_d;
                    dly2_q   <= comb1;
                    dly3_q   <= comb2;
                    sample_q <= sample_d;
                    clip_q   <= clip_d;
                end
            end
        end
    end

    assign o_sample = sample_q;
    assign o_clip   = clip_q;
    assign o_valid  = valid_q;

endmodule

// File: doc/sigma_delta_decimator.md
# sigma_delta_decimator

Receive-side counterpart of the second-order sigma-delta DAC. Accepts a 1-bit sigma-delta bitstream, one bit per qualified clock, and recovers signed 16-bit PCM samples with a third-order CIC (sinc3) decimation filter. Sits after an external comparator/modulator, or in loopback after the DAC for self-test. Uses the same full-scale convention as the DAC: ones-density d maps to sample value 2^15·(2d−1).

## Interface
- DECIM, 64, oversampling/decimation ratio; legal values 32, 64, 128, 256; L = log2(DECIM).
- i_clk  input  1  clock; all state updates on its rising edge.
- i_res  input  1  reset, synchronous, active-low.
- i_bit  input  1  sigma-delta input bit; 1 → +1, 0 → −1.
- i_bit_valid  input  1  qualifies i_bit; state advances only on cycles where it is high.
- o_sample  output  16  signed PCM sample, two's complement; held between updates.
- o_valid  output  1  one-cycle pulse; o_sample is new in this cycle.
- o_clip  output  1  valid only with o_valid; 1 when this sample was saturated.

## Operation
- Internal width W = 3L + 2 bits, signed: 20 bits at DECIM = 64.
- Input mapping: the integrator input is +1 or −1 in W bits, never 0.
- Integrators: three cascaded accumulators, I1 += x, I2 += I1, I3 += I2. All three update on every valid bit. Modular wrap-around is required; no saturation. Each stage uses the updated value of the previous stage in the same cycle (direct cascade).
- Phase counter: L bits, counts accepted bits 0..DECIM−1, wraps to 0.
- Comb stage runs on the accepted bit where the counter equals DECIM−1, using the updated I3 from that bit.
  - C1 = I3 − D1; C2 = C1 − D2; y = C2 − D3.
  - Update D1←I3, D2←C1, D3←C2. All comb arithmetic is modulo 2^W.
- Scaling: s = y >>> (3L − 15), arithmetic shift with floor rounding. At DECIM = 32 the shift is 0.
- Saturation:
  - s > 32767 → o_sample = 32767, o_clip = 1.
  - s < −32768 → o_sample = −32768, o_clip = 1.
  - Otherwise o_sample = s, o_clip = 0.
- Full-scale ones gives y = +DECIM^3 and clips to 32767. Full-scale zeros gives −DECIM^3, which is exactly −32768 with no clip.
- Start-up transient: the first two output samples after reset are filter fill and may be wrong. From the third sample on, output is exact for periodic input whose period divides DECIM.

## Timing
- Reset (i_res low at a rising edge): I1..I3, D1..D3, counter, o_sample and o_clip clear to 0; o_valid clears to 0. Reset overrides i_bit_valid in the same cycle.
- Reset mid-frame: the partial frame is discarded, no o_valid is produced for it, and counting restarts at 0 after release.
- Latency: the bit accepted at rising edge E (counter = DECIM−1) causes, on edge E itself, the registration of o_sample/o_clip and o_valid = 1 for the cycle following E. o_valid returns to 0 at the next edge.
- First o_valid after reset release occurs after exactly DECIM accepted bits.
- i_bit_valid low: all state holds; o_sample holds; o_valid = 0.
- Gaps in i_bit_valid do not change results, only timing.
- Maximum rate: one bit per clock, giving one sample every DECIM clocks. There is no backpressure; the consumer must take each o_valid pulse.

## Test plan
- Reset: drive i_res low 3 cycles with random i_bit/i_bit_valid → o_sample = 0, o_valid = 0, o_clip = 0. First o_valid comes exactly 64 accepted bits after release.
- All ones, DECIM = 64, i_bit_valid = 1 → from the 3rd sample on: o_sample = 32767, o_clip = 1. One o_valid every 64 cycles.
- All zeros → from the 3rd sample: o_sample = −32768, o_clip = 0.
- Repeating 1110 pattern → from the 3rd sample: o_sample = 16384, o_clip = 0. Repeating 10 pattern → from the 3rd sample: 0.
- Repeating 1110 with i_bit_valid toggling every cycle → same values (16384) at half the o_valid rate. Assert reset after 20 accepted bits → no o_valid for that partial frame; sample timing restarts from release.
- Loopback from the DAC driven with constant 8192 → after the 3rd sample, o_sample within 8192 ± 64. Sweep DECIM = 32 and 256 with the all-ones and 1110 cases: 32767 and 16384 respectively.
